mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
Parametrised, registered N:1 multiplexer. It is the sequential successor to the 32:1 structural mux.
- Direct mode: a registered select path.
- Scan mode: an internal sequencer walks every enabled channel once, in ascending order, and emits each one.
- Output: a valid/ready handshake that supports back-pressure.
- Used wherever many status or data lines are funnelled into one narrow consumer.

Parameters:
N, 32, number of input channels (>=2, need not be a power of 2)
W, 1, bits per channel
SELW, $clog2(N), select/channel-index width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock; the block has one clock
rst  input  1  synchronous, active-high reset
mode  input  1  0 = direct, 1 = scan; sampled only in IDLE
sel  input  SELW  direct-mode channel select
in_bus  input  N*W  channel k occupies in_bus[k*W +: W]
ch_mask  input  N  scan enable per channel; latched on start
start  input  1  begins a scan; honoured only in IDLE with mode=1
y  output  W  registered selected data
y_ch  output  SELW  channel index of y
y_valid  output  1  y/y_ch hold a valid item
y_ready  input  1  consumer accepts the item when y_valid && y_ready
busy  output  1  high in SCAN state
done  output  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (rst high at a clk edge): y=0, y_ch=0, y_valid=0, busy=0, done=0, state=IDLE, latched mask=0. Reset mid-scan aborts the scan immediately; no done pulse is produced.
- Output slot:
  - The slot is free when !y_valid || y_ready.
  - A capture loads y, y_ch and y_valid=1 on the next edge, so latency is 1 cycle.
  - Data is taken from in_bus live at the capture edge.
  - While y_valid && !y_ready, y and y_ch hold stable.
  - If the slot is free and nothing is captured, y_valid clears on the next edge.
  - Peak throughput is 1 item per cycle.
- States: IDLE, SCAN.
- IDLE, mode=0 (direct):
  - Captures in_bus[sel] every cycle the slot is free; y_ch=sel.
  - If sel>=N, then y=0 and y_ch=sel; the item is still valid.
  - start is ignored.
- IDLE, mode=1:
  - No captures.
  - On start: latch ch_mask into mask_q and go to SCAN with ptr = lowest set bit of ch_mask.
  - If ch_mask==0: stay in IDLE and pulse done on the next cycle; no item is emitted.
- SCAN:
  - busy=1.
  - When the slot is free, capture channel ptr, then advance ptr to the next set bit of mask_q above ptr. Masked-off channels are skipped in the same cycle, with no bubbles.
  - When the capture is for the highest set bit, the next state is IDLE and done pulses on that same edge.
  - done therefore coincides with y_valid rising for the final item; the final item may still await y_ready.
  - mode, sel, start and ch_mask changes are ignored during SCAN.
- Simultaneous events:
  - rst has priority over everything.
  - start in the same cycle that SCAN ends (the done edge) is ignored, because the state is not yet IDLE.
  - On the first IDLE cycle after a scan with mode=0, direct captures resume as soon as the slot is free.
- Width rules:
  - ptr is SELW bits and never exceeds N-1 in SCAN.
  - The next-set-bit search covers indices ptr+1..N-1 only; there is no wrap-around.

Decomposition:
- Shared package mux_pkg holds:
  - state typedef {IDLE, SCAN}
  - MODE_DIRECT=0 and MODE_SCAN=1 constants
  - a clog2 helper constant function
- One sub-module: mux_next_ch.
  - Parametrised N and SELW.
  - Combinational next-set-bit priority encoder.
  - Inputs: mask[N-1:0], from[SELW-1:0], incl (include the from bit).
  - Outputs: idx[SELW-1:0], found.
  - It serves both the start (lowest set bit, incl=1) and advance (incl=0) searches.

Test Plan:
1. N=32, W=1, mode=0, y_ready=1: sel=0/a=0x00000001, sel=1/a=0x00000002, sel=31/a=0x80000000, sel=28/a=0x10000000 -> y=1 each, one cycle after the change; y_ch tracks sel; sel=2 with a=0x00000001 -> y=0.
2. N=32, W=1, mode=1, in_bus=0xA5A5A5A5, ch_mask=0x0000000F, start pulse, y_ready=1 -> items (ch0,1),(ch1,0),(ch2,1),(ch3,0) on 4 consecutive cycles; done coincides with ch3 capture; busy is low afterwards.
3. Back-pressure: as test 2 but y_ready low for 3 cycles while ch1 is valid -> y=0 and y_ch=1 held stable; no item lost or duplicated; the total scan takes 4 items.
4. Sparse mask and non-power-of-2 width: N=5, W=8, ch_mask=5'b10010, in_bus={8'h44,8'h33,8'h22,8'h11,8'h00} -> items (ch1,0x11) then (ch4,0x44), back-to-back with no bubble; done pulses once.
5. ch_mask=0 start -> no y_valid; done pulses exactly one cycle later; state stays IDLE. Direct sel=6 with N=5 -> y=0, y_ch=6, y_valid=1.
6. rst asserted on the second cycle of a 32-channel scan -> next edge gives y_valid=0, busy=0, y=0, y_ch=0, with no done pulse. A subsequent start runs a full scan normally.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N:1 mux family.
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2, floored at 1 so a select field always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Next-set-bit priority encoder: lowest set bit of mask at index > from
// (or >= from when incl is set). No wrap-around.
module mux_next_ch
  #(parameter int unsigned N    = 32,
    parameter int unsigned SELW = 5)
  (
    input  logic [N-1:0]    mask,
    input  logic [SELW-1:0] from,
    input  logic            incl,
    output logic [SELW-1:0] idx,
    output logic            found
  );

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && mask[i] &&
          ((i > 32'(from)) || (incl && (i == 32'(from))))) begin
        idx   = SELW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N:1 mux with direct-select and masked ascending scan modes,
// emitting items through a valid/ready output slot.
module mux_nto1_scan
  import mux_pkg::*;
  #(parameter  int unsigned N    = 32,
    parameter  int unsigned W    = 1,
    localparam int unsigned SELW = clog2(N))
  (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_bus,
    input  logic [N-1:0]    ch_mask,
    input  logic            start,
    output logic [W-1:0]    y,
    output logic [SELW-1:0] y_ch,
    output logic            y_valid,
    input  logic            y_ready,
    output logic            busy,
    output logic            done
  );

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]      mask_q, mask_d;
  logic              done_d;
  logic              slot_free;
  logic              cap;
  logic [SELW-1:0]   cap_ch;
  logic [W-1:0]      cap_data;

  logic [N-1:0]      s_mask;
  logic [SELW-1:0]   s_from;
  logic              s_incl;
  logic [SELW-1:0]   s_idx;
  logic              s_found;

  // One encoder serves both searches: in IDLE it finds the first channel of
  // the incoming mask, in SCAN it finds the successor of ptr in the latched mask.
  assign s_mask = (state_q == SCAN) ? mask_q : ch_mask;
  assign s_from = (state_q == SCAN) ? ptr_q  : '0;
  assign s_incl = (state_q == IDLE);

  mux_next_ch #(.N(N), .SELW(SELW)) u_next (
    .mask  (s_mask),
    .from  (s_from),
    .incl  (s_incl),
    .idx   (s_idx),
    .found (s_found)
  );

  assign slot_free = !y_valid || y_ready;
  assign busy      = (state_q == SCAN);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    cap_ch  = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (mode == MODE_DIRECT) begin
          cap    = slot_free;
          cap_ch = sel;
        end else if (start) begin
          mask_d = ch_mask;
          if (s_found) begin
            state_d = SCAN;
            ptr_d   = s_idx;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          cap    = 1'b1;
          cap_ch = ptr_q;
          if (s_found) begin
            ptr_d = s_idx;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range selects fall through to zero data.
  always_comb begin
    cap_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(cap_ch) == k) cap_data = in_bus[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      done    <= 1'b0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      done    <= done_d;
      if (cap) begin
        y       <= cap_data;
        y_ch    <= cap_ch;
        y_valid <= 1'b1;
      end else if (slot_free) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan: a 32x1 instance and a 5x8 instance.
module tb_mux_nto1_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: N=32, W=1
  logic        a_mode, a_start, a_yv, a_rdy, a_busy, a_done;
  logic [4:0]  a_sel, a_ych;
  logic [31:0] a_in, a_mask;
  logic [0:0]  a_y;

  // Instance B: N=5, W=8
  logic        b_mode, b_start, b_yv, b_rdy, b_busy, b_done;
  logic [2:0]  b_sel, b_ych;
  logic [39:0] b_in;
  logic [4:0]  b_mask;
  logic [7:0]  b_y;

  mux_nto1_scan #(.N(32), .W(1)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel), .in_bus(a_in),
    .ch_mask(a_mask), .start(a_start), .y(a_y), .y_ch(a_ych),
    .y_valid(a_yv), .y_ready(a_rdy), .busy(a_busy), .done(a_done)
  );

  mux_nto1_scan #(.N(5), .W(8)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel), .in_bus(b_in),
    .ch_mask(b_mask), .start(b_start), .y(b_y), .y_ch(b_ych),
    .y_valid(b_yv), .y_ready(b_rdy), .busy(b_busy), .done(b_done)
  );

  int total = 0;
  int bad   = 0;

  // Handshake and done-pulse counters, sampled on the edge that consumes them.
  int a_acc  = 0;
  int a_dcnt = 0;
  int b_dcnt = 0;
  always @(posedge clk) begin
    if (a_yv && a_rdy) a_acc <= a_acc + 1;
    if (a_done) a_dcnt <= a_dcnt + 1;
    if (b_done) b_dcnt <= b_dcnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]  t1_sel [5];
    logic [31:0] t1_in  [5];
    logic        t1_y   [5];
    logic [31:0] pat;
    int snap, snap2;

    t1_sel = '{5'd0, 5'd1, 5'd31, 5'd28, 5'd2};
    t1_in  = '{32'h0000_0001, 32'h0000_0002, 32'h8000_0000, 32'h1000_0000, 32'h0000_0001};
    t1_y   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pat    = 32'hA5A5_A5A5;

    rst = 1'b1;
    a_mode = 1'b0; a_sel = '0; a_in = '0; a_mask = '0; a_start = 1'b0; a_rdy = 1'b1;
    b_mode = 1'b0; b_sel = '0; b_in = '0; b_mask = '0; b_start = 1'b0; b_rdy = 1'b1;

    @(negedge clk);
    tick();
    chk("rst_a_y", a_y, 0);
    chk("rst_a_ych", a_ych, 0);
    chk("rst_a_yv", a_yv, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_yv", b_yv, 0);
    rst = 1'b0;

    // Direct mode
    for (int i = 0; i < 5; i++) begin
      a_sel = t1_sel[i];
      a_in  = t1_in[i];
      tick();
      chk("dir_y", a_y, t1_y[i]);
      chk("dir_ych", a_ych, t1_sel[i]);
      chk("dir_yv", a_yv, 1);
    end

    // Scan of channels 0..3 with ready held high
    a_mode = 1'b1; a_in = pat; a_mask = 32'h0000_000F; a_start = 1'b1;
    tick();
    chk("scan_busy0", a_busy, 1);
    chk("scan_yv0", a_yv, 0);
    a_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("scan_ych", a_ych, k);
      chk("scan_y", a_y, pat[k]);
      chk("scan_yv", a_yv, 1);
      chk("scan_done", a_done, (k == 3));
      chk("scan_busy", a_busy, (k != 3));
    end
    tick();
    chk("scan_end_done", a_done, 0);
    chk("scan_end_yv", a_yv, 0);
    chk("scan_end_busy", a_busy, 0);

    // Back-pressure on ch1
    snap = a_acc;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    chk("bp_ch0", a_ych, 0);
    tick();
    chk("bp_ch1", a_ych, 1);
    a_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_ych", a_ych, 1);
      chk("bp_hold_y", a_y, 0);
      chk("bp_hold_yv", a_yv, 1);
      chk("bp_hold_busy", a_busy, 1);
      chk("bp_hold_done", a_done, 0);
    end
    a_rdy = 1'b1;
    tick();
    chk("bp_ch2", a_ych, 2);
    chk("bp_ch2_y", a_y, 1);
    tick();
    chk("bp_ch3", a_ych, 3);
    chk("bp_ch3_done", a_done, 1);
    tick();
    chk("bp_yv_clear", a_yv, 0);
    chk("bp_items", a_acc - snap, 4);

    // Sparse mask, non-power-of-2 N, wide channels
    snap2 = b_dcnt;
    b_mode = 1'b1; b_in = 40'h44_33_22_11_00; b_mask = 5'b10010; b_start = 1'b1;
    tick();
    chk("sp_busy", b_busy, 1);
    b_start = 1'b0;
    tick();
    chk("sp_ch1", b_ych, 1);
    chk("sp_y1", b_y, 8'h11);
    chk("sp_done1", b_done, 0);
    tick();
    chk("sp_ch4", b_ych, 4);
    chk("sp_y4", b_y, 8'h44);
    chk("sp_yv4", b_yv, 1);
    chk("sp_done4", b_done, 1);
    chk("sp_busy4", b_busy, 0);
    tick();
    chk("sp_yv_clear", b_yv, 0);
    chk("sp_dcnt", b_dcnt - snap2, 1);

    // Empty mask, then out-of-range direct select
    snap2 = b_dcnt;
    b_mask = '0; b_start = 1'b1;
    tick();
    chk("em_done", b_done, 1);
    chk("em_yv", b_yv, 0);
    chk("em_busy", b_busy, 0);
    b_start = 1'b0;
    tick();
    chk("em_done_clr", b_done, 0);
    chk("em_yv2", b_yv, 0);
    chk("em_busy2", b_busy, 0);
    b_mode = 1'b0; b_sel = 3'd6;
    tick();
    chk("oor_y", b_y, 0);
    chk("oor_ych", b_ych, 6);
    chk("oor_yv", b_yv, 1);
    chk("em_dcnt", b_dcnt - snap2, 1);

    // Reset mid-scan, then a full 32-channel scan
    a_mask = '1; a_in = pat; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    snap = a_dcnt;
    rst = 1'b1;
    tick();
    chk("mr_yv", a_yv, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_y", a_y, 0);
    chk("mr_ych", a_ych, 0);
    chk("mr_done", a_done, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("mr_nodone", a_dcnt - snap, 0);
    snap = a_dcnt;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("full_ych", a_ych, k);
      chk("full_y", a_y, pat[k]);
      chk("full_done", a_done, (k == 31));
    end
    tick();
    chk("full_dcnt", a_dcnt - snap, 1);
    chk("full_busy", a_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
